// File: rtl/lfsr_galois_gen.sv
// lfsr_galois_gen: parametrised Galois LFSR word source with a valid/ready
// output handshake, run-time seed load, period-wrap pulse and all-zero
// lockup flag.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN. When it is defined, an
// all-zero state is replaced on the following edge by seed_q, or by SEED if
// seed_q is zero.
module lfsr_galois_gen #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED  = 32'h1,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             lockup
);

    // RUN: q holds a consumable word. LOAD: the cycle after a load, when q
    // has just been replaced and is not yet offered to the consumer.
    typedef enum logic {RUN, LOAD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] step_val;
    logic             adv;

    // STEPS single-bit Galois shifts chained in one cycle
    always_comb begin
        step_val = q_q;
        for (int i = 0; i < STEPS; i++) begin
            step_val = (step_val >> 1) ^ (step_val[0] ? TAPS : '0);
        end
    end

    assign adv = (state_q == RUN) & out_ready & ~load;

    // Next-state selection: load wins, then lockup recovery (optional), then advance
    always_comb begin
        q_d     = q_q;
        seed_d  = seed_q;
        state_d = RUN;
        wrap_d  = 1'b0;
        if (load) begin
            q_d     = load_value;
            seed_d  = load_value;
            state_d = LOAD;
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        // A zero state is only reachable by loading zero, so this fires from
        // LOAD. RUN, and therefore out_valid, returns together with the
        // recovered state.
        else if (q_q == '0) begin
            q_d = (seed_q != '0) ? seed_q : SEED;
        end
`endif
        else if (adv) begin
            q_d    = step_val;
            wrap_d = (step_val == seed_q);
        end
        lockup_d = (q_d == '0);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            q_q      <= SEED;
            seed_q   <= SEED;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign q         = q_q;
    assign wrap      = wrap_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Directed bench for lfsr_galois_gen: default configuration, STEPS=2, and a
// 4-bit full-period sequence, all checked against hand-computed vectors.
module tb_lfsr_galois_gen;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: default parameters
    logic        load_a, ready_a, valid_a, wrap_a, lockup_a;
    logic [31:0] lv_a, q_a;
    lfsr_galois_gen dut_a (
        .clk(clk), .reset_n(reset_n), .load(load_a), .load_value(lv_a),
        .out_ready(ready_a), .out_valid(valid_a), .q(q_a), .wrap(wrap_a), .lockup(lockup_a)
    );

    // DUT B: two steps per advance
    logic        load_b, ready_b, valid_b, wrap_b, lockup_b;
    logic [31:0] lv_b, q_b;
    lfsr_galois_gen #(.STEPS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .load(load_b), .load_value(lv_b),
        .out_ready(ready_b), .out_valid(valid_b), .q(q_b), .wrap(wrap_b), .lockup(lockup_b)
    );

    // DUT C: 4-bit maximal-length LFSR
    logic        load_c, ready_c, valid_c, wrap_c, lockup_c;
    logic [3:0]  lv_c, q_c;
    lfsr_galois_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut_c (
        .clk(clk), .reset_n(reset_n), .load(load_c), .load_value(lv_c),
        .out_ready(ready_c), .out_valid(valid_c), .q(q_c), .wrap(wrap_c), .lockup(lockup_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq_c [15];

    initial begin
        seq_c = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                  4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
        reset_n = 1'b0;
        load_a = 0; ready_a = 0; lv_a = '0;
        load_b = 0; ready_b = 0; lv_b = '0;
        load_c = 0; ready_c = 0; lv_c = '0;
        tick(); tick();

        // Reset values
        check("rst_q",      q_a, 64'h1);
        check("rst_valid",  valid_a, 1);
        check("rst_wrap",   wrap_a, 0);
        check("rst_lockup", lockup_a, 0);
        reset_n = 1'b1;
        tick();
        check("idle_hold_q", q_a, 64'h1);

        // Two handshakes, then hold
        ready_a = 1;
        tick();
        check("adv1_q", q_a, 64'h8020_0003);
        tick();
        check("adv2_q", q_a, 64'hC030_0002);
        check("adv2_wrap", wrap_a, 0);
        ready_a = 0;
        tick(); tick();
        check("hold_q", q_a, 64'hC030_0002);
        check("hold_valid", valid_a, 1);

        // Load with ready high: load wins, no advance
        load_a = 1; lv_a = 32'h1234_5678; ready_a = 1;
        tick();
        check("load_q", q_a, 64'h1234_5678);
        check("load_valid", valid_a, 0);
        check("load_wrap", wrap_a, 0);
        load_a = 0;
        tick();
        check("load_run_q", q_a, 64'h1234_5678);
        check("load_run_valid", valid_a, 1);
        ready_a = 0;

        // Load while already in LOAD restarts LOAD
        load_a = 1; lv_a = 32'h0000_00A5;
        tick();
        lv_a = 32'h0000_0001;
        tick();
        check("reload_q", q_a, 64'h1);
        check("reload_valid", valid_a, 0);
        load_a = 0;
        tick();
        check("reload_run_valid", valid_a, 1);
        // seed_q is now 1: one advance then a wrap check is not possible in
        // one step, so verify a plain advance from the loaded seed
        ready_a = 1;
        tick();
        check("reseed_adv_q", q_a, 64'h8020_0003);
        check("reseed_adv_wrap", wrap_a, 0);
        ready_a = 0;

        // Lockup via load of zero
        load_a = 1; lv_a = '0;
        tick();
        check("lock_q", q_a, 64'h0);
        check("lock_flag", lockup_a, 1);
        check("lock_valid", valid_a, 0);
        load_a = 0;
        tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("recover_q", q_a, 64'h1);
        check("recover_lockup", lockup_a, 0);
        check("recover_valid", valid_a, 1);
`else
        check("lock_hold_q", q_a, 64'h0);
        check("lock_hold_flag", lockup_a, 1);
        check("lock_hold_valid", valid_a, 1);
        ready_a = 1;
        tick();
        check("lock_adv_q", q_a, 64'h0);
        check("lock_adv_flag", lockup_a, 1);
        ready_a = 0;
        load_a = 1; lv_a = 32'h5;
        tick();
        check("unlock_q", q_a, 64'h5);
        check("unlock_flag", lockup_a, 0);
        load_a = 0;
        tick();
`endif

        // STEPS=2: one handshake jumps two single steps
        check("s2_rst_q", q_b, 64'h1);
        ready_b = 1;
        tick();
        check("s2_adv_q", q_b, 64'hC030_0002);
        ready_b = 0;

        // 4-bit full period; wrap only on the 15th advance
        ready_c = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("w4_q%0d", i), q_c, seq_c[i]);
            check($sformatf("w4_wrap%0d", i), wrap_c, (i == 14));
        end
        ready_c = 0;
        tick();
        check("w4_wrap_clear", wrap_c, 0);
        check("w4_hold_q", q_c, 64'h1);

        // Reset mid-operation returns to reset state
        ready_c = 1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_q", q_c, 64'h1);
        check("async_rst_valid", valid_c, 1);
        ready_c = 0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
